// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: groups the bus-side request/response signals and the SRAM pad
// signals of sram_ctrl.
//   Bus side : req, we, size, addr, wdata (to controller); busy, resp, err,
//              rdata (from controller).
//   Pad side : sram_ce_bar, sram_oe_bar, sram_we_bar, sram_addr, sram_dq_o,
//              sram_dq_oe (from controller); sram_dq_i (to controller).
// modport slave is the controller. modport master is everything around it,
// i.e. the bus decoder plus the pad wrapper that returns sram_dq_i.
interface sram_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        resp;
    logic        err;
    logic [31:0] rdata;
    logic        sram_ce_bar;
    logic        sram_oe_bar;
    logic        sram_we_bar;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_i;

    modport master (
        output req, we, size, addr, wdata, sram_dq_i,
        input  busy, resp, err, rdata,
        input  sram_ce_bar, sram_oe_bar, sram_we_bar, sram_addr, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  req, we, size, addr, wdata, sram_dq_i,
        output busy, resp, err, rdata,
        output sram_ce_bar, sram_oe_bar, sram_we_bar, sram_addr, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequencer for a 512 KiB x8 asynchronous SRAM. Byte, halfword and
// word requests are split into byte-wide SRAM cycles; each access strobe lasts
// WAIT_CYCLES+1 clocks. Writes are framed by one setup and one hold cycle.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - sram_ctrl_if.slave: request/response bus and SRAM pad signals
// All outputs are registered.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StSetup, StAcc, StHold, StDone} state_e;

    state_e      r_state;
    logic        r_we;
    logic [18:0] r_base;
    logic [31:0] r_wdata;
    logic [1:0]  r_last;     // byte count minus one
    logic [1:0]  r_idx;      // current byte index k
    logic [3:0]  r_wcnt;     // cycles already spent in the current strobe
    logic        r_busy;
    logic        r_resp;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_ce_bar;
    logic        r_oe_bar;
    logic        r_we_bar;
    logic [18:0] r_addr;
    logic [7:0]  r_dq_o;
    logic        r_dq_oe;

    logic [1:0]  w_next_idx;
    logic [18:0] w_next_addr;
    logic [7:0]  w_next_byte;
    logic        w_acc_last;
    logic        w_more;

    assign w_next_idx  = r_idx + 2'd1;
    // 19-bit add gives the modulo-2^19 address wrap for free.
    assign w_next_addr = r_base + 19'(w_next_idx);
    assign w_next_byte = r_wdata[{w_next_idx, 3'b000} +: 8];
    assign w_acc_last  = (r_wcnt == 4'(WAIT_CYCLES));
    assign w_more      = (r_idx != r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_last   <= '0;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_busy   <= 1'b0;
            r_resp   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_ce_bar <= 1'b1;
            r_oe_bar <= 1'b1;
            r_we_bar <= 1'b1;
            r_addr   <= '0;
            r_dq_o   <= '0;
            r_dq_oe  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_base  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_last  <= bus.size;
                        r_idx   <= '0;
                        r_wcnt  <= '0;
                        r_rdata <= '0;
                        r_busy  <= 1'b1;
                        if (bus.size == 2'd3) begin
                            // Illegal size: answer at once, SRAM pins untouched.
                            r_state <= StDone;
                            r_resp  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_ce_bar <= 1'b0;
                            r_addr   <= bus.addr;
                            if (bus.we) begin
                                r_state <= StSetup;
                                r_dq_oe <= 1'b1;
                                r_dq_o  <= bus.wdata[7:0];
                            end else begin
                                r_state  <= StAcc;
                                r_oe_bar <= 1'b0;
                            end
                        end
                    end
                end
                StSetup: begin
                    r_state  <= StAcc;
                    r_we_bar <= 1'b0;
                end
                StAcc: begin
                    if (w_acc_last) begin
                        r_wcnt <= '0;
                        if (r_we) begin
                            r_state  <= StHold;
                            r_we_bar <= 1'b1;
                        end else begin
                            r_rdata[{r_idx, 3'b000} +: 8] <= bus.sram_dq_i;
                            if (w_more) begin
                                // Next read byte follows with ce_bar/oe_bar held low.
                                r_idx  <= w_next_idx;
                                r_addr <= w_next_addr;
                            end else begin
                                r_state  <= StDone;
                                r_ce_bar <= 1'b1;
                                r_oe_bar <= 1'b1;
                                r_resp   <= 1'b1;
                            end
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                StHold: begin
                    if (w_more) begin
                        r_state <= StSetup;
                        r_idx   <= w_next_idx;
                        r_addr  <= w_next_addr;
                        r_dq_o  <= w_next_byte;
                    end else begin
                        r_state  <= StDone;
                        r_ce_bar <= 1'b1;
                        r_dq_oe  <= 1'b0;
                        r_resp   <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_resp  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.resp        = r_resp;
    assign bus.err         = r_err;
    assign bus.rdata       = r_rdata;
    assign bus.sram_ce_bar = r_ce_bar;
    assign bus.sram_oe_bar = r_oe_bar;
    assign bus.sram_we_bar = r_we_bar;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_dq_o   = r_dq_o;
    assign bus.sram_dq_oe  = r_dq_oe;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl. A pin-level SRAM model
// answers the pads; a reference byte array predicts every response, which is
// queued at issue time and compared by an independent monitor on resp.
module tb_sram_ctrl;
    localparam int unsigned W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if ifc ();

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ce_lo;
        int          oe_lo;
        int          we_lo;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;

    logic [7:0] mem     [0:524287];
    logic [7:0] ref_mem [0:524287];

    always @(posedge clk) cyc <= cyc + 1;

    // Window of addresses used by the tests: 0x7FFF0..0x7FFFF and 0x00..0x1F.
    function automatic logic [18:0] win_addr(input int i);
        return (i < 16) ? 19'(19'h7FFF0 + 19'(i)) : 19'(i - 16);
    endfunction

    function automatic logic [7:0] init_byte(input logic [18:0] a);
        case (a)
            19'h10: return 8'h11;
            19'h11: return 8'h22;
            19'h12: return 8'h33;
            19'h13: return 8'h44;
            19'h05: return 8'hA5;
            19'h18, 19'h19, 19'h1A, 19'h1B: return 8'hFF;
            default: return 8'(a * 29 + 7);
        endcase
    endfunction

    // Pin-level SRAM: read data when selected and output-enabled, write on the
    // rising edge of we_bar while ce_bar is low.
    assign ifc.sram_dq_i = (!ifc.sram_ce_bar && !ifc.sram_oe_bar) ? mem[ifc.sram_addr] : 8'hEE;

    initial begin
        for (int i = 0; i < 48; i++) mem[win_addr(i)] = init_byte(win_addr(i));
        forever begin
            @(posedge ifc.sram_we_bar);
            if (ifc.sram_ce_bar === 1'b0) mem[ifc.sram_addr] = ifc.sram_dq_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pad protocol every cycle, strobe-cycle tallies, scoreboard pop on resp.
    int   ce_lo = 0, oe_lo = 0, we_lo = 0;
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pin_excl", 32'({ifc.sram_we_bar | ifc.sram_oe_bar,
                                 !(ifc.sram_dq_oe && !ifc.sram_oe_bar)}), 32'd3);
            if (prev_resp) begin
                chk("err_cleared", 32'(ifc.err), 32'd0);
                chk("gap_ce_bar", 32'(ifc.sram_ce_bar), 32'd1);
            end
            if (!ifc.busy) begin
                chk("idle_ce_bar", 32'(ifc.sram_ce_bar), 32'd1);
                ce_lo = 0; oe_lo = 0; we_lo = 0;
            end else begin
                if (!ifc.sram_ce_bar) ce_lo++;
                if (!ifc.sram_oe_bar) oe_lo++;
                if (!ifc.sram_we_bar) we_lo++;
            end
            if (ifc.resp) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got resp=1 expected no resp (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", ifc.rdata, e.rdata);
                    chk("err", 32'(ifc.err), 32'(e.err));
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("ce_lo_cycles", 32'(ce_lo), 32'(e.ce_lo));
                    chk("oe_lo_cycles", 32'(oe_lo), 32'(e.oe_lo));
                    chk("we_lo_cycles", 32'(we_lo), 32'(e.we_lo));
                end
                ce_lo = 0; oe_lo = 0; we_lo = 0;
            end
            prev_resp = ifc.resp;
        end
    end

    // Issue one request at a negedge once the controller is idle; optionally
    // predict and queue the response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [18:0] a,
                         input logic [31:0] wd, input bit push);
        exp_t e;
        int   n;
        int   t = 0;
        while (ifc.busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            $display("FAIL issue_timeout: got busy=1 for %0d cycles expected idle", t);
            return;
        end
        n = int'(sz) + 1;
        e.rdata = '0; e.err = 1'b0; e.issue = cyc;
        e.ce_lo = 0; e.oe_lo = 0; e.we_lo = 0;
        if (sz == 2'd3) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (w) begin
            if (push)
                for (int k = 0; k < n; k++) ref_mem[19'(a + 19'(k))] = wd[8*k +: 8];
            e.lat   = n * int'(W + 3) + 1;
            e.ce_lo = n * int'(W + 3);
            e.we_lo = n * int'(W + 1);
        end else begin
            for (int k = 0; k < n; k++) e.rdata[8*k +: 8] = ref_mem[19'(a + 19'(k))];
            e.lat   = n * int'(W + 1) + 1;
            e.ce_lo = n * int'(W + 1);
            e.oe_lo = n * int'(W + 1);
        end
        if (push) sb.push_back(e);
        ifc.req = 1'b1; ifc.we = w; ifc.size = sz; ifc.addr = a; ifc.wdata = wd;
        @(negedge clk);
        ifc.req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || ifc.busy !== 1'b0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        ifc.req = 1'b0; ifc.we = 1'b0; ifc.size = 2'd0; ifc.addr = '0; ifc.wdata = '0;
        for (int i = 0; i < 48; i++) ref_mem[win_addr(i)] = init_byte(win_addr(i));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        chk("rst_ce_bar", 32'(ifc.sram_ce_bar), 32'd1);
        chk("rst_oe_bar", 32'(ifc.sram_oe_bar), 32'd1);
        chk("rst_we_bar", 32'(ifc.sram_we_bar), 32'd1);
        chk("rst_dq_oe", 32'(ifc.sram_dq_oe), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_resp", 32'(ifc.resp), 32'd0);
        chk("rst_err", 32'(ifc.err), 32'd0);
        chk("rst_rdata", ifc.rdata, 32'd0);
        chk("rst_addr", 32'(ifc.sram_addr), 32'd0);
        chk("rst_dq_o", 32'(ifc.sram_dq_o), 32'd0);
        mon_en = 1'b1;

        // Word read, halfword write across the wrap, rdata clearing, illegal size.
        issue(1'b0, 2'd2, 19'h00010, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 19'h7FFFF, 32'h0000BEEF, 1'b1);
        drain();
        chk("wrap_byte0", 32'(mem[19'h7FFFF]), 32'hEF);
        chk("wrap_byte1", 32'(mem[19'h00000]), 32'hBE);
        issue(1'b0, 2'd2, 19'h00018, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 19'h00005, 32'h0, 1'b1);
        issue(1'b1, 2'd3, 19'h00003, 32'h12345678, 1'b1);

        // Requests during a busy write and in its DONE cycle are dropped.
        issue(1'b1, 2'd2, 19'h7FFF8, 32'hA1B2C3D4, 1'b1);
        ifc.req = 1'b1; ifc.we = 1'b0; ifc.size = 2'd0; ifc.addr = 19'h0;
        repeat (2) @(negedge clk);
        ifc.req = 1'b0;
        t = 0;
        while (ifc.resp !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("resp_seen", 32'(ifc.resp), 32'd1);
        ifc.req = 1'b1;
        @(negedge clk);
        ifc.req = 1'b0;
        chk("done_req_ignored", 32'(ifc.busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("no_extra_busy", 32'(ifc.busy), 32'd0);

        // Reset on the third cycle of a word write.
        issue(1'b1, 2'd2, 19'h40000, 32'hCAFEBABE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ce_bar", 32'(ifc.sram_ce_bar), 32'd1);
        chk("abort_we_bar", 32'(ifc.sram_we_bar), 32'd1);
        chk("abort_dq_oe", 32'(ifc.sram_dq_oe), 32'd0);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_resp", 32'(ifc.resp), 32'd0);
        repeat (3) @(negedge clk);
        issue(1'b0, 2'd0, 19'h00010, 32'h0, 1'b1);

        // Randomized mix near the address wrap, mostly back-to-back.
        for (int i = 0; i < 80; i++) begin
            logic        w;
            logic [1:0]  sz;
            logic [18:0] a;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 19'(19'h7FFF0 + 19'($urandom_range(0, 31)));
            issue(w, sz, a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        for (int i = 0; i < 48; i++)
            chk("final_mem", 32'(mem[win_addr(i)]), 32'(ref_mem[win_addr(i)]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
